// File: rtl/grid_clear_ctrl_pkg.sv
// Shared definitions for the 4x3 grid line-clear controller.
// Holds the FSM state encoding, grid geometry constants and row helpers,
// including the row-removal shift used when a full row is cleared.
package grid_clear_ctrl_pkg;

  localparam int unsigned GRID_W = 12;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned ROWS   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit offset of a row inside the grid word (row 0 is the top row).
  function automatic int unsigned row_lsb(input int unsigned row);
    return row * ROW_W;
  endfunction

  function automatic logic [ROW_W-1:0] get_row(input logic [GRID_W-1:0] g,
                                               input int unsigned      row);
    return g[row_lsb(row) +: ROW_W];
  endfunction

  // Remove the row selected by one-hot sel: rows above it drop by one,
  // the top row empties, rows below it are untouched.
  function automatic logic [GRID_W-1:0] clear_row(input logic [GRID_W-1:0] g,
                                                  input logic [ROWS-1:0]   sel);
    logic [GRID_W-1:0] r;
    r = g;
    for (int unsigned k = 0; k < ROWS; k++) begin
      if (sel[k]) begin
        r[row_lsb(0) +: ROW_W] = '0;
        for (int unsigned i = 1; i <= k; i++) begin
          r[row_lsb(i) +: ROW_W] = get_row(g, i - 1);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/detect_full.sv
// Full-row detector for the 4x3 grid.
// Ports: grid (in, 12) current grid; full_c (out, 3) one-hot of the
// highest-priority full row, top row winning; zero when no row is full.
module detect_full
  import grid_clear_ctrl_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  output logic [ROWS-1:0]   full_c
);

  logic found;

  // Scan top to bottom and keep only the first full row.
  always_comb begin
    full_c = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (!found && (&get_row(grid, i))) begin
        full_c[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_clear_ctrl.sv
// Placement / line-clear sequencer for the 4x3 occupancy grid.
// Ports: clk, rst_n (async active-low); place_valid/place_mask/place_ready
// placement handshake; flush synchronous grid/score clear; grid current
// grid; collision and done one-cycle pulses; lines_last rows cleared by the
// last completed placement; score saturating total of cleared rows.
module grid_clear_ctrl
  import grid_clear_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               place_valid,
  input  logic [GRID_W-1:0]  place_mask,
  output logic               place_ready,
  input  logic               flush,
  output logic [GRID_W-1:0]  grid,
  output logic               collision,
  output logic               done,
  output logic [1:0]         lines_last,
  output logic [SCORE_W-1:0] score
);

  state_e              state_q, state_d;
  logic [GRID_W-1:0]   grid_d;
  logic [ROWS-1:0]     sel_q, sel_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [SCORE_W-1:0]  score_d;
  logic [1:0]          lines_d;
  logic                done_d, coll_d;
  logic [ROWS-1:0]     full_c;

  detect_full u_detect (
    .grid   (grid),
    .full_c (full_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grid        <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      score       <= '0;
      lines_last  <= '0;
      done        <= 1'b0;
      collision   <= 1'b0;
      place_ready <= 1'b1;
    end else begin
      state_q     <= state_d;
      grid        <= grid_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      score       <= score_d;
      lines_last  <= lines_d;
      done        <= done_d;
      collision   <= coll_d;
      place_ready <= (state_d == ST_IDLE);
    end
  end

  // Next-state and next-output logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    grid_d  = grid;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    score_d = score;
    lines_d = lines_last;
    done_d  = 1'b0;
    coll_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (place_valid && place_ready) begin
          if ((place_mask & grid) != '0) begin
            coll_d = 1'b1;
          end else begin
            grid_d  = grid | place_mask;
            cnt_d   = '0;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (full_c == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          sel_d   = full_c;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        grid_d = clear_row(grid, sel_q);
        cnt_d  = cnt_q + 2'd1;
        if (score != '1) begin
          score_d = score + SCORE_W'(1);
        end
        state_d = ST_CHECK;
      end
      ST_DONE: begin
        lines_d = cnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      grid_d  = '0;
      cnt_d   = '0;
      score_d = '0;
      lines_d = '0;
      done_d  = 1'b0;
      coll_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_grid_clear_ctrl.sv
// Self-checking bench for grid_clear_ctrl with a queue-based scoreboard.
module tb_grid_clear_ctrl;

  logic        clk;
  logic        rst_n;
  logic        place_valid;
  logic [11:0] place_mask;
  logic        place_ready;
  logic        flush;
  logic [11:0] grid;
  logic        collision;
  logic        done;
  logic [1:0]  lines_last;
  logic [7:0]  score;

  typedef struct {
    logic [11:0] grid;
    logic [1:0]  lines;
    logic [7:0]  score;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [11:0] model_grid;
  int          model_score;
  int          checks;
  int          failures;
  int          cyc;
  bit          ok;
  bit          acc;

  grid_clear_ctrl #(.SCORE_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .place_valid (place_valid),
    .place_mask  (place_mask),
    .place_ready (place_ready),
    .flush       (flush),
    .grid        (grid),
    .collision   (collision),
    .done        (done),
    .lines_last  (lines_last),
    .score       (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: first full row from the top, or -1.
  function automatic int first_full(input logic [11:0] g);
    for (int r = 0; r < 3; r++) begin
      if (((g >> (4 * r)) & 12'hF) == 12'hF) return r;
    end
    return -1;
  endfunction

  // Reference model: delete row r, lower-index rows move one row down.
  function automatic logic [11:0] drop_row(input logic [11:0] g, input int r);
    logic [11:0] low;
    logic [11:0] keep;
    low  = 12'((1 << (4 * r)) - 1);
    keep = ~12'((1 << (4 * (r + 1))) - 1);
    return (g & keep) | ((g & low) << 4);
  endfunction

  function automatic void model_reset();
    model_grid  = 12'h000;
    model_score = 0;
    sb.delete();
  endfunction

  // Present one placement for a single edge; push the predicted outcome.
  task automatic issue(input logic [11:0] mask, output bit accepted);
    exp_t x;
    int   r;
    int   n;
    accepted = ((mask & model_grid) == 12'h000);
    if (accepted) begin
      x.grid = model_grid | mask;
      n = 0;
      r = first_full(x.grid);
      while (r >= 0) begin
        x.grid = drop_row(x.grid, r);
        n++;
        if (model_score < 255) model_score++;
        r = first_full(x.grid);
      end
      x.lines    = 2'(n);
      x.score    = 8'(model_score);
      model_grid = x.grid;
      sb.push_back(x);
    end
    place_valid = 1'b1;
    place_mask  = mask;
    @(posedge clk); #1;
    place_valid = 1'b0;
    place_mask  = 12'h000;
  endtask

  // Step until done is seen or the cycle budget runs out (no checking here).
  task automatic wait_done(input int start, output int c, output bit seen);
    c    = start;
    seen = 1'b0;
    while (c < start + 16) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; place_valid = 1'b0; place_mask = 12'h000; flush = 1'b0;
    model_reset();
    step(2);
    checks++;
    if (grid !== 12'h000 || score !== 8'd0 || lines_last !== 2'd0) begin
      failures++;
      $display("FAIL reset_regs grid=%h score=%0d lines=%0d required 000/0/0", grid, score, lines_last);
    end
    checks++;
    if (done !== 1'b0 || collision !== 1'b0 || place_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags done=%b coll=%b ready=%b required 0/0/1", done, collision, place_ready);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_top_row();
    issue(12'h00F, acc);
    checks++;
    if (grid !== 12'h00F) begin
      failures++; $display("FAIL top_merge grid=%h required 00f", grid);
    end
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc != 4) begin
      failures++; $display("FAIL top_done_cycle seen=%b cycle=%0d required 4", ok, cyc);
    end
    checks++;
    if (grid !== e.grid || score !== e.score || score !== 8'd1) begin
      failures++; $display("FAIL top_result grid=%h score=%0d required %h/%0d", grid, score, e.grid, e.score);
    end
    step(1);
    checks++;
    if (lines_last !== e.lines || done !== 1'b0 || place_ready !== 1'b1) begin
      failures++; $display("FAIL top_lines lines=%0d done=%b ready=%b required %0d/0/1", lines_last, done, place_ready, e.lines);
    end
  endtask

  task automatic test_middle_shift();
    issue(12'h0E3, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc != 2 || grid !== 12'h0E3) begin
      failures++; $display("FAIL mid_setup seen=%b cycle=%0d grid=%h required 2/0e3", ok, cyc, grid);
    end
    step(1);
    issue(12'h010, acc);
    checks++;
    if (grid !== 12'h0F3) begin
      failures++; $display("FAIL mid_merge grid=%h required 0f3", grid);
    end
    step(2);
    checks++;
    if (grid !== 12'h030) begin
      failures++; $display("FAIL mid_shift grid=%h required 030", grid);
    end
    wait_done(3, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc != 4 || grid !== e.grid || score !== e.score) begin
      failures++; $display("FAIL mid_done cycle=%0d grid=%h score=%0d required 4/%h/%0d", cyc, grid, score, e.grid, e.score);
    end
    step(1);
    checks++;
    if (lines_last !== 2'd1) begin
      failures++; $display("FAIL mid_lines lines=%0d required 1", lines_last);
    end
  endtask

  task automatic test_two_rows();
    do_flush();
    issue(12'hFF0, acc);
    step(2);
    checks++;
    if (grid !== 12'hF00) begin
      failures++; $display("FAIL two_first grid=%h required f00", grid);
    end
    step(2);
    checks++;
    if (grid !== 12'h000) begin
      failures++; $display("FAIL two_second grid=%h required 000", grid);
    end
    wait_done(5, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc != 6 || score !== e.score || score !== 8'd2) begin
      failures++; $display("FAIL two_done cycle=%0d score=%0d required 6/%0d", cyc, score, e.score);
    end
    step(1);
    checks++;
    if (lines_last !== e.lines || lines_last !== 2'd2) begin
      failures++; $display("FAIL two_lines lines=%0d required 2", lines_last);
    end
  endtask

  task automatic test_zero_mask();
    issue(12'h000, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc != 2 || grid !== e.grid) begin
      failures++; $display("FAIL zero_done cycle=%0d grid=%h required 2/%h", cyc, grid, e.grid);
    end
    step(1);
    checks++;
    if (lines_last !== 2'd0 || score !== e.score) begin
      failures++; $display("FAIL zero_lines lines=%0d score=%0d required 0/%0d", lines_last, score, e.score);
    end
  endtask

  task automatic test_collision();
    issue(12'h030, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    step(1);
    issue(12'h010, acc);
    checks++;
    if (collision !== 1'b1 || grid !== 12'h030 || place_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL coll_pulse coll=%b grid=%h ready=%b done=%b required 1/030/1/0", collision, grid, place_ready, done);
    end
    step(1);
    checks++;
    if (collision !== 1'b0) begin
      failures++; $display("FAIL coll_width coll=%b required 0", collision);
    end
    wait_done(2, cyc, ok);
    checks++;
    if (ok || grid !== 12'h030 || score !== e.score || lines_last !== e.lines) begin
      failures++; $display("FAIL coll_quiet done_seen=%b grid=%h score=%0d lines=%0d required 0/030/%0d/%0d", ok, grid, score, lines_last, e.score, e.lines);
    end
  endtask

  task automatic test_saturation();
    do_flush();
    for (int i = 0; i < 84; i++) begin
      issue(12'hFFF, acc);
      wait_done(1, cyc, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || cyc != 8 || score !== e.score) begin
        failures++; $display("FAIL sat_fill%0d cycle=%0d score=%0d required 8/%0d", i, cyc, score, e.score);
      end
      step(1);
    end
    issue(12'hF0F, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || score !== 8'd254 || score !== e.score) begin
      failures++; $display("FAIL sat_preset score=%0d required 254", score);
    end
    step(1);
    issue(12'hFF0, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || score !== 8'd255 || score !== e.score) begin
      failures++; $display("FAIL sat_top score=%0d required 255", score);
    end
    step(1);
    checks++;
    if (lines_last !== 2'd2) begin
      failures++; $display("FAIL sat_lines lines=%0d required 2", lines_last);
    end
    issue(12'h00F, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || score !== 8'd255) begin
      failures++; $display("FAIL sat_hold score=%0d required 255", score);
    end
    step(1);
  endtask

  task automatic test_reset_mid();
    issue(12'hFFF, acc);
    step(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (grid !== 12'h000 || score !== 8'd0 || lines_last !== 2'd0) begin
      failures++; $display("FAIL rmid_regs grid=%h score=%0d lines=%0d required 000/0/0", grid, score, lines_last);
    end
    checks++;
    if (done !== 1'b0 || collision !== 1'b0 || place_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_flags done=%b coll=%b ready=%b required 0/0/1", done, collision, place_ready);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1);
  endtask

  task automatic test_flush_mid();
    issue(12'h00F, acc);
    wait_done(1, cyc, ok);
    e = sb.pop_front();
    step(1);
    issue(12'hFFF, acc);
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    model_reset();
    checks++;
    if (grid !== 12'h000 || score !== 8'd0 || lines_last !== 2'd0 || place_ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL fmid_state grid=%h score=%0d lines=%0d ready=%b done=%b required 000/0/0/1/0", grid, score, lines_last, place_ready, done);
    end
    wait_done(0, cyc, ok);
    checks++;
    if (ok || grid !== 12'h000) begin
      failures++; $display("FAIL fmid_quiet done_seen=%b grid=%h required 0/000", ok, grid);
    end
  endtask

  task automatic test_flush_with_place();
    place_valid = 1'b1;
    place_mask  = 12'h00F;
    flush       = 1'b1;
    step(1);
    place_valid = 1'b0;
    place_mask  = 12'h000;
    flush       = 1'b0;
    checks++;
    if (grid !== 12'h000 || place_ready !== 1'b1) begin
      failures++; $display("FAIL fplace grid=%h ready=%b required 000/1", grid, place_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_top_row();
    test_middle_shift();
    test_two_rows();
    test_zero_mask();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_flush_mid();
    test_flush_with_place();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
